mixcolumns_seq: RTL and testbench

- Parametrised, column-serial AES MixColumns engine supporting both forward (MixColumns) and inverse (InvMixColumns) modes, selected per block.
- Accepts a 128-bit state over a valid/ready handshake and processes LANES columns per cycle.
- Returns the transformed state over a second valid/ready handshake.
- Sits between ShiftRows/InvShiftRows and AddRoundKey in the shared encrypt/decrypt round datapath.
- Replaces the fixed, inverse-only, fully combinational 4-column transform.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/mixcolumns_col.sv | 36 +++
 rtl/mixcolumns_seq.sv | 96 +++++++++
 tb/tb_mixcolumns_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES column-transform types, FSM encoding and GF(2^8) multiply helpers.
// Multiplies are xtime chains over the AES polynomial 0x11b.
package aes_pkg;

  typedef logic [31:0] col_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Coefficients m0..m3 applied to a_r, a_(r+1), a_(r+2), a_(r+3).
  localparam logic [7:0] FwdCoef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [7:0] InvCoef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return xtime(a);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Dispatch on a constant coefficient; synthesis folds the selection away.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
    case (m)
      8'h01:   return a;
      8'h02:   return gf_mul2(a);
      8'h03:   return gf_mul3(a);
      8'h09:   return gf_mul9(a);
      8'h0b:   return gf_mul11(a);
      8'h0d:   return gf_mul13(a);
      8'h0e:   return gf_mul14(a);
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mixcolumns_col.sv
// Combinational MixColumns / InvMixColumns on a single 32-bit column.
// Byte r of the column sits at [31-8r -: 8].
module mixcolumns_col
  import aes_pkg::*;
(
  input  col_t col,
  input  logic inv,
  output col_t res
);

  logic [7:0] a [4];
  logic [7:0] bf;
  logic [7:0] bi;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a[r] = col[31-8*r -: 8];
    end
  end

  always_comb begin
    res = '0;
    bf  = '0;
    bi  = '0;
    for (int r = 0; r < 4; r++) begin
      bf = '0;
      bi = '0;
      for (int j = 0; j < 4; j++) begin
        bf = bf ^ gf_mul(a[(r+j)%4], FwdCoef[j]);
        bi = bi ^ gf_mul(a[(r+j)%4], InvCoef[j]);
      end
      res[31-8*r -: 8] = inv ? bi : bf;
    end
  end

endmodule

// File: rtl/mixcolumns_seq.sv
// Column-serial AES MixColumns engine, forward or inverse per block, LANES columns
// per cycle between two valid/ready handshakes.
module mixcolumns_seq
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned NCYC = 4 / LANES;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("mixcolumns_seq: LANES must be 1, 2 or 4");
  end

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              inv_q;
  col_t [3:0]        work_q;   // element 3 is column 0 (MSBs)
  col_t [3:0]        work_d;
  col_t              lane_in  [LANES];
  col_t              lane_out [LANES];

  function automatic logic [1:0] lane_col(input logic [CW-1:0] c, input int unsigned l);
    return 2'(c * LANES + l);
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mixcolumns_col u_col (
      .col (lane_in[l]),
      .inv (inv_q),
      .res (lane_out[l])
    );
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l] = work_q[2'd3 - lane_col(cnt_q, l)];
    end
  end

  always_comb begin
    work_d = work_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      work_d[2'd3 - lane_col(cnt_q, l)] = lane_out[l];
    end
  end

  // Accepting in DONE while the result drains gives zero-bubble back-to-back blocks.
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_state = work_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      work_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (in_valid && in_ready) begin
            work_q  <= in_state;
            inv_q   <= in_inv;
            cnt_q   <= '0;
            state_q <= StRun;
          end else if ((state_q == StDone) && out_ready) begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(NCYC - 1)) begin
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Scoreboard bench for mixcolumns_seq: directed AES vectors, backpressure, mode isolation,
// mid-block reset, LANES=1/2/4 latency and a forward/inverse round trip.
module tb_mixcolumns_seq;

  localparam logic [127:0] FIn  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FOut = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] IIn  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] IOut = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
  localparam logic [127:0] Ones = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, iv24, in_inv, out_ready;
  logic [127:0] in_state;
  logic         in_ready1, out_valid1, busy1;
  logic         in_ready2, out_valid2, busy2;
  logic         in_ready4, out_valid4, busy4;
  logic [127:0] out_state1, out_state2, out_state4;

  logic [127:0] exp_q [$];
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  mixcolumns_seq #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_inv(in_inv),
    .in_state(in_state), .out_valid(out_valid1), .out_ready(out_ready),
    .out_state(out_state1), .busy(busy1)
  );

  mixcolumns_seq #(.LANES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv24), .in_ready(in_ready2), .in_inv(in_inv),
    .in_state(in_state), .out_valid(out_valid2), .out_ready(out_ready),
    .out_state(out_state2), .busy(busy2)
  );

  mixcolumns_seq #(.LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv24), .in_ready(in_ready4), .in_inv(in_inv),
    .in_state(in_state), .out_valid(out_valid4), .out_ready(out_ready),
    .out_state(out_state4), .busy(busy4)
  );

  // Generic shift-and-add GF(2^8) multiply for the reference model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] x;
    logic [7:0] p;
    x = {1'b0, a};
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] mc_fwd(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
      for (int k = 0; k < 4; k++) begin
        r[127-32*c-8*k -: 8] = gmul(a[k], 8'h02) ^ gmul(a[(k+1)%4], 8'h03) ^
                               a[(k+2)%4] ^ a[(k+3)%4];
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a block; on the accepting edge push its expected result.
  task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] exp,
                      output int tries);
    logic acc;
    acc   = 1'b0;
    tries = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_inv   = inv;
    in_state = s;
    while (!acc && tries < 200) begin
      #1 acc = in_ready1;
      @(posedge clk);
      tries++;
      if (!acc) @(negedge clk);
    end
    if (acc) exp_q.push_back(exp);
    else chk("accept_timeout", 128'(tries), 128'(1));
  endtask

  task automatic release_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_left", 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: pop and compare on every output handshake.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid1 && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_out", out_state1, 128'hx);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out", out_state1, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries, lat1, lat2, lat4, bad;
    logic [127:0] x, y;

    rst_n = 1'b0; in_valid = 1'b0; iv24 = 1'b0; in_inv = 1'b0; out_ready = 1'b0;
    in_state = '0;
    #12;
    chk("rst_in_ready",  128'(in_ready1),  128'(1));
    chk("rst_out_valid", 128'(out_valid1), 128'(0));
    chk("rst_busy",      128'(busy1),      128'(0));
    chk("rst_out_state", out_state1,       128'(0));
    @(negedge clk) rst_n = 1'b1;

    // Inverse vector on all three LANES variants, accepted on the same edge.
    @(negedge clk);
    in_valid = 1'b1; iv24 = 1'b1; in_inv = 1'b1; in_state = IIn;
    #1 chk("all_ready", {in_ready1, in_ready2, in_ready4}, 128'h7);
    @(posedge clk);
    exp_q.push_back(IOut);
    #1 in_valid = 1'b0; iv24 = 1'b0;
    chk("busy_run", {busy2, busy4}, 128'h3);
    lat1 = 0; lat2 = 0; lat4 = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 == 0) lat1 = n;
      if (out_valid2 && lat2 == 0) lat2 = n;
      if (out_valid4 && lat4 == 0) lat4 = n;
    end
    chk("lat_lanes1", 128'(lat1), 128'(4));
    chk("lat_lanes2", 128'(lat2), 128'(2));
    chk("lat_lanes4", 128'(lat4), 128'(1));
    chk("inv_lanes2", out_state2, IOut);
    chk("inv_lanes4", out_state4, IOut);
    @(negedge clk) out_ready = 1'b1;
    drain();

    // Forward vector, exact latency, then backpressure and zero-bubble follow-on.
    out_ready = 1'b0;
    send(FIn, 1'b0, FOut, tries);
    #1 in_valid = 1'b0;
    lat1 = 0;
    while (!out_valid1 && lat1 < 20) begin
      @(posedge clk); #1;
      lat1++;
    end
    chk("lat_fwd", 128'(lat1), 128'(4));
    chk("busy_done", 128'(busy1), 128'(1));
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (!out_valid1 || in_ready1 || out_state1 !== FOut) bad++;
    end
    chk("backpressure_hold", 128'(bad), 128'(0));
    out_ready = 1'b1;
    send(IIn, 1'b1, IOut, tries);
    chk("zero_bubble_accept", 128'(tries), 128'(1));
    release_in();
    drain();

    // in_inv toggling during RUN must not disturb an inverse block.
    send(IIn, 1'b1, IOut, tries);
    #1 in_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk) in_inv = ~in_inv;
    end
    drain();

    // Reset in the second RUN cycle discards the block.
    send(FIn, 1'b0, FOut, tries);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid1), 128'(0));
    chk("midrst_in_ready",  128'(in_ready1),  128'(1));
    void'(exp_q.pop_back());
    @(negedge clk) rst_n = 1'b1;
    send(IIn, 1'b1, IOut, tries);
    release_in();
    drain();

    // Fixed points.
    send('0,   1'b0, '0,   tries);
    send(Ones, 1'b0, Ones, tries);
    send('0,   1'b1, '0,   tries);
    send(Ones, 1'b1, Ones, tries);
    release_in();
    drain();

    // Round trip: forward against the model, then inverse back to the original.
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = mc_fwd(x);
      send(x, 1'b0, y, tries);
      send(y, 1'b1, x, tries);
    end
    release_in();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
